// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and constants for the SDRAM round-robin arbiter.
// The optional watchdog is enabled by defining JTFRAME_SDRAM_ARB_TIMEOUT_EN.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } arb_state_e;

    localparam logic [7:0] WD_LIMIT = 8'd255;

    // Width of an index able to address n slots (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Link between the arbiter (master) and the SDRAM controller (slave).
interface jtframe_sdram_arb_if #(
    parameter int AW = 22
);
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic [1:0]    sdram_bank;
    logic          sdram_ack;
    logic [31:0]   data_read;
    logic          data_rdy;
    logic          refresh_en;

    modport master (
        output sdram_req, sdram_addr, sdram_bank, refresh_en,
        input  sdram_ack, data_read, data_rdy
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_bank, refresh_en,
        output sdram_ack, data_read, data_rdy
    );
endinterface

// File: rtl/jtframe_rr_prio.sv
// Combinational round-robin picker: first requesting slot at or after ptr,
// wrapping modulo SLOTS.
module jtframe_rr_prio
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = idx_width(SLOTS)
) (
    input  logic [SLOTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             valid
);
    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % SLOTS);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter granting game slots single reads from one SDRAM port.
// Define JTFRAME_SDRAM_ARB_TIMEOUT_EN to add an 8-bit transaction watchdog.
//
// state    | meaning
// IDLE     | no transaction; may grant the next requester
// WAIT_ACK | sdram_req held high until the controller accepts
// WAIT_RDY | request accepted, waiting for read data
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic                clk_rom,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS*2-1:0]  slot_bank,
    output logic [SLOTS-1:0]    slot_ack,
    output logic [SLOTS-1:0]    slot_rdy,
    output logic [31:0]         slot_dout,
    output logic                busy,
    jtframe_sdram_arb_if.master sdram
);
    localparam int IW = idx_width(SLOTS);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [IW-1:0]  winner_q, winner_d;
    logic           req_q, req_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [1:0]     bank_q, bank_d;
    logic [SLOTS-1:0] ack_q, ack_d;
    logic [SLOTS-1:0] rdy_q, rdy_d;
    logic [31:0]    dout_q, dout_d;
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
    logic [7:0]     wd_q, wd_d;
`endif

    logic [IW-1:0]  pick;
    logic           pick_valid;
    logic [IW-1:0]  rr_next;

    jtframe_rr_prio #(.SLOTS(SLOTS), .IW(IW)) u_prio (
        .req    (slot_req),
        .ptr    (rr_q),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign rr_next = (winner_q == IW'(SLOTS - 1)) ? '0 : winner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        req_d    = req_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        ack_d    = '0;
        rdy_d    = '0;
        dout_d   = dout_q;
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid && !downloading) begin
                    state_d  = WAIT_ACK;
                    winner_d = pick;
                    addr_d   = slot_addr[pick*AW +: AW];
                    bank_d   = slot_bank[pick*2 +: 2];
                    req_d    = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    req_d           = 1'b0;
                    ack_d[winner_q] = 1'b1;
                    state_d         = WAIT_RDY;
                    // Fast controllers may return data in the accept cycle.
                    if (sdram.data_rdy) begin
                        rdy_d[winner_q] = 1'b1;
                        dout_d          = sdram.data_read;
                        rr_d            = rr_next;
                        state_d         = IDLE;
                    end
                end
            end
            WAIT_RDY: begin
                if (sdram.data_rdy) begin
                    rdy_d[winner_q] = 1'b1;
                    dout_d          = sdram.data_read;
                    rr_d            = rr_next;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
        // Abort keeps rr so the same slot gets first chance on retry.
        if (state_q == IDLE) begin
            wd_d = WD_LIMIT;
        end else if (wd_q != 8'd0) begin
            wd_d = wd_q - 8'd1;
        end else if (state_d == state_q) begin
            state_d = IDLE;
            req_d   = 1'b0;
            if (state_q == WAIT_ACK) ack_d[winner_q] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            winner_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            bank_q   <= '0;
            ack_q    <= '0;
            rdy_q    <= '0;
            dout_q   <= '0;
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
            wd_q     <= WD_LIMIT;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            dout_q   <= dout_d;
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign slot_ack         = ack_q;
    assign slot_rdy         = rdy_q;
    assign slot_dout        = dout_q;
    assign busy             = (state_q != IDLE);
    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_bank = bank_q;
    assign sdram.refresh_en = downloading | ((state_q == IDLE) & ~|slot_req);
endmodule
